card_round_ctrl: RTL and testbench

CARD_ROUND_CTRL -- requirements
Module: card_round_ctrl

---
 rtl/card_game_pkg.sv | 38 +++
 rtl/hand_accum.sv | 36 +++
 rtl/card_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_card_round_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_game_pkg.sv
// Shared definitions for the card round controller: FSM encoding, result codes,
// rank limits and the half-unit scoring helpers.
package card_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAL_P  = 3'd1,
        ST_DEAL_D  = 3'd2,
        ST_PLAYER  = 3'd3,
        ST_DEALER  = 3'd4,
        ST_COMPARE = 3'd5,
        ST_SHOW    = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;

    localparam logic [3:0] RANK_MIN     = 4'd1;
    localparam logic [3:0] RANK_PIP_MAX = 4'd10;
    localparam logic [3:0] RANK_MAX     = 4'd13;

    localparam int         HALVES_PER_POINT = 2;
    localparam logic [4:0] FACE_HALVES      = 5'd1;

    // Pip cards count their face value, court cards count half a point.
    function automatic logic [4:0] card_halves(input logic [3:0] rank);
        if (rank <= RANK_PIP_MAX)
            return {rank, 1'b0};
        return FACE_HALVES;
    endfunction

    function automatic logic rank_legal(input logic [3:0] rank);
        return (rank >= RANK_MIN) && (rank <= RANK_MAX);
    endfunction

endpackage

// File: rtl/hand_accum.sv
// One hand of cards: card count and running score in half-units, with
// bust/exact flags against the target score.
module hand_accum
    import card_game_pkg::*;
#(
    parameter int SW     = 7,
    parameter int TARGET = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          accept,
    input  logic [3:0]    rank,
    output logic [2:0]    cnt,
    output logic [SW-1:0] score,
    output logic          bust,
    output logic          exact
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            score <= '0;
        end else if (clear) begin
            cnt   <= '0;
            score <= '0;
        end else if (accept) begin
            cnt   <= cnt + 3'd1;
            score <= score + SW'(card_halves(rank));
        end
    end

    assign bust  = score > SW'(TARGET);
    assign exact = score == SW'(TARGET);

endmodule

// File: rtl/card_round_ctrl.sv
// Round/game controller for a two-hand card game with a deck handshake.
// Define CARD_CHARLIE_EN to let a full, non-bust player hand win outright.
module card_round_ctrl
    import card_game_pkg::*;
#(
    parameter int MAX_CARDS    = 5,
    parameter int NUM_ROUNDS   = 4,
    parameter int LIMIT        = 10,
    parameter int DEALER_AUTO  = 1,
    parameter int DEALER_STAND = 14,
    localparam int SW          = $clog2(MAX_CARDS * 20 + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          hit,
    input  logic          stand,
    output logic          card_req,
    input  logic          card_valid,
    input  logic [3:0]    card_value,
    output logic [SW-1:0] player_score,
    output logic [SW-1:0] dealer_score,
    output logic [2:0]    player_cnt,
    output logic [2:0]    dealer_cnt,
    output logic [3:0]    last_card,
    output logic [2:0]    state,
    output logic [1:0]    result,
    output logic [3:0]    round,
    output logic [3:0]    p_wins,
    output logic [3:0]    d_wins,
    output logic          game_over,
    output logic          card_err
);

    localparam int            TARGET   = HALVES_PER_POINT * LIMIT + 1;
    localparam logic [2:0]    MAX_CNT  = 3'(MAX_CARDS);
    localparam logic [SW-1:0] STAND_TH = SW'(DEALER_STAND);

    state_t     cur_state, nxt_state;
    logic       hit_pending, legal, xfer, take_card;
    logic       new_round, new_game, p_accept, d_accept;
    logic       p_bust, p_exact, d_bust, d_exact;
    logic       manual_dealer, dealer_want, hit_acc;
    logic [1:0] cmp_result;

    assign manual_dealer = (DEALER_AUTO == 0);
    assign legal         = rank_legal(card_value);
    assign xfer          = card_req && card_valid;
    assign take_card     = xfer && legal;
    assign new_round     = start && (cur_state inside {ST_IDLE, ST_SHOW, ST_DONE});
    assign new_game      = start && (cur_state == ST_DONE);
    assign p_accept      = take_card && (cur_state inside {ST_DEAL_P, ST_PLAYER});
    assign d_accept      = take_card && (cur_state inside {ST_DEAL_D, ST_DEALER});
    assign dealer_want   = (dealer_score < STAND_TH) && !d_bust && (dealer_cnt < MAX_CNT);
    assign hit_acc       = hit && !stand && !hit_pending &&
                           (((cur_state == ST_PLAYER) && (player_cnt < MAX_CNT)) ||
                            ((cur_state == ST_DEALER) && manual_dealer && (dealer_cnt < MAX_CNT)));
    assign state         = cur_state;

    hand_accum #(.SW(SW), .TARGET(TARGET)) u_player (
        .clk(clk), .rst_n(rst_n), .clear(new_round), .accept(p_accept), .rank(card_value),
        .cnt(player_cnt), .score(player_score), .bust(p_bust), .exact(p_exact)
    );

    hand_accum #(.SW(SW), .TARGET(TARGET)) u_dealer (
        .clk(clk), .rst_n(rst_n), .clear(new_round), .accept(d_accept), .rank(card_value),
        .cnt(dealer_cnt), .score(dealer_score), .bust(d_bust), .exact(d_exact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= ST_IDLE;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE, ST_SHOW, ST_DONE: if (start) nxt_state = ST_DEAL_P;
            ST_DEAL_P:                 if (take_card) nxt_state = ST_DEAL_D;
            ST_DEAL_D:                 if (take_card) nxt_state = ST_PLAYER;
            ST_PLAYER: begin
                if (p_bust)
                    nxt_state = ST_COMPARE;
`ifdef CARD_CHARLIE_EN
                else if (player_cnt == MAX_CNT)
                    nxt_state = ST_COMPARE;
`endif
                else if (stand || p_exact || (player_cnt == MAX_CNT))
                    nxt_state = ST_DEALER;
            end
            ST_DEALER: begin
                if (manual_dealer) begin
                    if (stand || d_bust || d_exact || (dealer_cnt == MAX_CNT))
                        nxt_state = ST_COMPARE;
                end else if (!dealer_want) begin
                    nxt_state = ST_COMPARE;
                end
            end
            ST_COMPARE: nxt_state = (round == 4'(NUM_ROUNDS)) ? ST_DONE : ST_SHOW;
            default:    nxt_state = ST_IDLE;
        endcase
    end

    // The auto dealer requests purely from its hand, so no pending flag is needed there.
    always_comb begin
        card_req  = 1'b0;
        game_over = 1'b0;
        case (cur_state)
            ST_DEAL_P, ST_DEAL_D: card_req  = 1'b1;
            ST_PLAYER:            card_req  = hit_pending;
            ST_DEALER:            card_req  = manual_dealer ? hit_pending : dealer_want;
            ST_DONE:              game_over = 1'b1;
            default:              card_req  = 1'b0;
        endcase
    end

    always_comb begin
        cmp_result = RES_DEALER;
        if (p_bust)
            cmp_result = RES_DEALER;
`ifdef CARD_CHARLIE_EN
        else if (player_cnt == MAX_CNT)
            cmp_result = RES_PLAYER;
`endif
        else if (d_bust)
            cmp_result = RES_PLAYER;
        else if (player_score > dealer_score)
            cmp_result = RES_PLAYER;
    end

    // A pending hit is dropped whenever the turn ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_pending <= 1'b0;
        else if ((nxt_state != cur_state) || take_card)
            hit_pending <= 1'b0;
        else if (hit_acc)
            hit_pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round     <= '0;
            result    <= RES_NONE;
            p_wins    <= '0;
            d_wins    <= '0;
            card_err  <= 1'b0;
            last_card <= '0;
        end else begin
            if (new_round) begin
                round  <= new_game ? 4'd1 : round + 4'd1;
                result <= RES_NONE;
            end else if (cur_state == ST_COMPARE) begin
                result <= cmp_result;
            end
            if (new_game) begin
                p_wins <= '0;
                d_wins <= '0;
            end else if (cur_state == ST_COMPARE) begin
                if ((cmp_result == RES_PLAYER) && (p_wins != 4'd15)) p_wins <= p_wins + 4'd1;
                if ((cmp_result == RES_DEALER) && (d_wins != 4'd15)) d_wins <= d_wins + 4'd1;
            end
            if (new_game)
                card_err <= 1'b0;
            else if (xfer && !legal)
                card_err <= 1'b1;
            if (take_card)
                last_card <= card_value;
        end
    end

endmodule

// File: tb/tb_card_round_ctrl.sv
// Randomized self-checking bench for card_round_ctrl against a hand-arithmetic game model.
module tb_card_round_ctrl;

    localparam int NUM_ROUNDS = 4;
    localparam int MAX_CARDS  = 5;
    localparam int TARGET     = 21;
    localparam int STAND      = 14;
    localparam int SW         = $clog2(MAX_CARDS * 20 + 1);

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, hit = 1'b0, stand = 1'b0;
    logic          card_valid = 1'b0;
    logic [3:0]    card_value = 4'd0;
    logic          card_req, game_over, card_err;
    logic [SW-1:0] player_score, dealer_score;
    logic [2:0]    player_cnt, dealer_cnt, state;
    logic [3:0]    last_card, round, p_wins, d_wins;
    logic [1:0]    result;

    card_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .stand(stand),
        .card_req(card_req), .card_valid(card_valid), .card_value(card_value),
        .player_score(player_score), .dealer_score(dealer_score),
        .player_cnt(player_cnt), .dealer_cnt(dealer_cnt), .last_card(last_card),
        .state(state), .result(result), .round(round), .p_wins(p_wins), .d_wins(d_wins),
        .game_over(game_over), .card_err(card_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int exp_round = 0, exp_pw = 0, exp_dw = 0, exp_err = 0, exp_last = 0;
    int ps, ds, pc, dc;
    int forced[$];

`ifdef CARD_CHARLIE_EN
    localparam bit CHARLIE = 1'b1;
`else
    localparam bit CHARLIE = 1'b0;
`endif

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int halves(input int r);
        return (r <= 10) ? 2 * r : 1;
    endfunction

    function automatic int nextCard();
        if (forced.size() > 0) return forced.pop_front();
        return int'($urandom_range(1, 13));
    endfunction

    task automatic waitReq(input string tag);
        int n = 0;
        while (card_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (card_req !== 1'b1) checkOutput(tag, card_req, 1);
    endtask

    task automatic supplyCard(input int v);
        waitReq("req_timeout");
        repeat ($urandom_range(0, 2)) tick();
        card_valid = 1'b1;
        card_value = 4'(v);
        tick();
        card_valid = 1'b0;
        card_value = 4'd0;
        exp_last   = v;
    endtask

    task automatic supplyIllegal(input int v);
        waitReq("req_timeout_err");
        card_valid = 1'b1;
        card_value = 4'(v);
        tick();
        card_valid = 1'b0;
        card_value = 4'd0;
        exp_err    = 1;
        checkOutput("err_flag", card_err, 1);
        checkOutput("err_req_held", card_req, 1);
        checkOutput("err_cnt_hold", player_cnt, 0);
    endtask

    // One full round driven from start to SHOW/DONE, mirrored in the model hand totals.
    task automatic applyStimulus(input int n_hits, input bit inject);
        int v, n, exp_res, exp_exit;
        if (exp_round == NUM_ROUNDS) begin
            exp_round = 1; exp_pw = 0; exp_dw = 0; exp_err = 0;
        end else begin
            exp_round++;
        end
        ps = 0; ds = 0; pc = 0; dc = 0;

        start = 1'b1; tick(); start = 1'b0;
        checkOutput("start_state", state, 1);
        checkOutput("start_round", round, exp_round);
        checkOutput("start_pwins", p_wins, exp_pw);
        checkOutput("start_dwins", d_wins, exp_dw);
        checkOutput("start_result", result, 0);
        checkOutput("start_pcnt", player_cnt, 0);
        checkOutput("start_dscore", dealer_score, 0);
        checkOutput("start_err", card_err, exp_err);

        if (inject) supplyIllegal(($urandom_range(0, 2) == 0) ? 0 : 13 + int'($urandom_range(1, 2)));
        v = nextCard(); supplyCard(v); ps += halves(v); pc++;
        checkOutput("deal_pscore", player_score, ps);
        v = nextCard(); supplyCard(v); ds += halves(v); dc++;
        checkOutput("deal_state", state, 3);
        checkOutput("deal_dscore", dealer_score, ds);

        for (int i = 0; i < n_hits; i++) begin
            if (ps >= TARGET || pc == MAX_CARDS) break;
            hit = 1'b1; tick(); hit = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                hit = 1'b1; start = 1'b1; tick(); hit = 1'b0; start = 1'b0;
            end
            v = nextCard(); supplyCard(v); ps += halves(v); pc++;
        end
        checkOutput("player_score", player_score, ps);
        checkOutput("player_cnt", player_cnt, pc);

        if (ps >= TARGET || pc == MAX_CARDS) tick();
        else begin stand = 1'b1; tick(); stand = 1'b0; end
        exp_exit = (ps > TARGET || (CHARLIE && pc == MAX_CARDS)) ? 5 : 4;
        checkOutput("turn_exit", state, exp_exit);

        if (exp_exit == 4) begin
            while (ds < STAND && dc < MAX_CARDS) begin
                v = nextCard(); supplyCard(v); ds += halves(v); dc++;
            end
        end
        n = 0;
        while (!(state == 3'd6 || state == 3'd7) && n < 20) begin
            tick();
            n++;
        end

        if (ps > TARGET)                           exp_res = 2;
        else if (CHARLIE && pc == MAX_CARDS)       exp_res = 1;
        else if (ds > TARGET)                      exp_res = 1;
        else if (ps > ds)                          exp_res = 1;
        else                                       exp_res = 2;
        if (exp_res == 1) exp_pw = (exp_pw < 15) ? exp_pw + 1 : 15;
        else              exp_dw = (exp_dw < 15) ? exp_dw + 1 : 15;

        checkOutput("end_state", state, (exp_round == NUM_ROUNDS) ? 7 : 6);
        checkOutput("result", result, exp_res);
        checkOutput("end_pscore", player_score, ps);
        checkOutput("end_dscore", dealer_score, ds);
        checkOutput("end_pcnt", player_cnt, pc);
        checkOutput("end_dcnt", dealer_cnt, dc);
        checkOutput("p_wins", p_wins, exp_pw);
        checkOutput("d_wins", d_wins, exp_dw);
        checkOutput("round", round, exp_round);
        checkOutput("game_over", game_over, (exp_round == NUM_ROUNDS) ? 1 : 0);
        checkOutput("card_err", card_err, exp_err);
        checkOutput("last_card", last_card, exp_last);
        checkOutput("end_req", card_req, 0);
    endtask

    initial begin
        repeat (3) tick();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_req", card_req, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_round", round, 0);
        checkOutput("rst_pscore", player_score, 0);
        checkOutput("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        tick();

        forced = '{10, 5, 11};        applyStimulus(1, 1'b0);
        forced = '{10, 1, 1};         applyStimulus(2, 1'b0);
        forced = '{6, 3, 4};          applyStimulus(0, 1'b0);
        forced = '{7, 3, 4};          applyStimulus(0, 1'b0);

        forced = '{7};                applyStimulus(int'($urandom_range(0, 3)), 1'b1);
        forced = '{1, 5, 1, 1, 1, 11}; applyStimulus(4, 1'b0);
        forced.delete();
        repeat (2) applyStimulus(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);

        repeat (8) applyStimulus(int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);

        start = 1'b1; tick(); start = 1'b0;
        checkOutput("abort_pre_state", state, 1);
        card_valid = 1'b1;
        card_value = 4'd5;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_state", state, 0);
        checkOutput("abort_req", card_req, 0);
        tick();
        checkOutput("abort_pcnt", player_cnt, 0);
        checkOutput("abort_pscore", player_score, 0);
        checkOutput("abort_round", round, 0);
        checkOutput("abort_last", last_card, 0);
        card_valid = 1'b0;
        card_value = 4'd0;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
